cpu_step_controller: RTL and testbench
======================================

Name: cpu_step_controller

Overview:
- Clock-enable sequencer for the multi-cycle computer on the Nexys A7 board; replaces driving the CPU clock directly from a debounced button.
- Takes debounced button levels and issues single-cycle cpu_ce pulses in three modes: single-cycle step, single-instruction step, and free-run at a divided rate with a PC breakpoint.
- Sits between the debouncer and the CPU. The CPU runs on clk and advances only when cpu_ce=1.

Parameters:
FETCH_STATE, 4'd0, fsm_state encoding of the CPU fetch state
RUN_DIV, 10_000_000, clk cycles between cpu_ce pulses in RUN (min 2)
MAX_INSTR_CYCLES, 16, cpu_ce pulses allowed per instruction step before timeout

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
btn_cycle  in  1  debounced level: step one CPU cycle
btn_instr  in  1  debounced level: step one instruction
btn_run  in  1  debounced level: toggle free-run
bp_enable  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
fetch_pc  in  32  CPU PC
fsm_state  in  4  CPU control-FSM state; registered, updates the cycle after a cpu_ce pulse
cpu_ce  out  1  CPU clock enable, one-cycle pulses
running  out  1  1 while in RUN
bp_hit  out  1  1 while in BP_HALT
timeout  out  1  sticky: last instruction step hit MAX_INSTR_CYCLES
cycle_count  out  32  cpu_ce pulses issued
instr_count  out  32  instructions started
ctrl_state  out  2  current controller state, for debug display

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, divider 0, edge-detect history cleared. Buttons already held at reset release do not fire.
- Button events:
  - Each button is rising-edge detected on a registered level, so an event is a one-cycle pulse.
  - Simultaneous events resolve by priority: btn_run > btn_instr > btn_cycle; lower-priority events in the same cycle are dropped.
- States: IDLE=0, STEP_INSTR=1, RUN=2, BP_HALT=3.
- IDLE:
  - cycle event: cpu_ce=1 for exactly one cycle in the next cycle; stay in IDLE.
  - instr event: go to STEP_INSTR and clear timeout.
  - run event: go to RUN, divider=0, clear the "first instruction" flag.
- STEP_INSTR:
  - Alternates a PULSE cycle (cpu_ce=1, pulse counter +1) with a CHECK cycle (cpu_ce=0).
  - CHECK with fsm_state==FETCH_STATE: go to IDLE.
  - CHECK otherwise: if the pulse counter equals MAX_INSTR_CYCLES, set timeout and go to IDLE; else take another PULSE.
  - The first PULSE is never preceded by a CHECK. All button events are ignored in this state.
- RUN:
  - Divider counts 0..RUN_DIV-1; on the tick where divider==RUN_DIV-1, evaluate the breakpoint, then either pulse or halt.
  - Breakpoint condition: bp_enable && fsm_state==FETCH_STATE && fetch_pc==bp_addr && first-instruction flag set. When true, go to BP_HALT with no pulse.
  - Otherwise cpu_ce=1 for that cycle. The first-instruction flag is set after the first pulse issued in RUN, so resuming at the breakpoint PC does not re-halt immediately.
  - run event: go to IDLE, no pulse that cycle, even if it coincides with a tick.
  - Other button events are ignored.
- BP_HALT:
  - bp_hit=1, cpu_ce=0.
  - run event: go to RUN, with the same entry actions as from IDLE.
  - instr or cycle event: same actions as from IDLE.
- Counters:
  - cycle_count +1 on every cpu_ce pulse.
  - instr_count +1 on a cpu_ce pulse issued while fsm_state==FETCH_STATE.
  - Both wrap modulo 2^32 (0xFFFFFFFF -> 0).
- Outputs: all outputs are registered; no combinational path from inputs to cpu_ce.
- Reset mid-operation: immediately aborts STEP_INSTR or RUN. cpu_ce drops asynchronously, so no partial pulse reaches the CPU.

Decomposition:
- Package cpu_step_pkg: state encodings (IDLE/STEP_INSTR/RUN/BP_HALT), width localparams (CNT_W=32, STATE_W=4).
- Sub-module edge_rise: registered rising-edge detector with asynchronous reset, instantiated three times.

Test Plan:
- Reset held, then released with btn_cycle already high -> no cpu_ce pulse; all counters 0; ctrl_state=0.
- btn_cycle rising edge with fsm_state=0 -> exactly one cpu_ce pulse; cycle_count=1; instr_count=1.
- btn_instr, with a CPU model stepping fsm_state 0->1->2->3->0 on each ce -> 4 cpu_ce pulses, each followed by a CHECK gap; return to IDLE; instr_count=1; timeout=0.
- btn_instr, with fsm_state stuck at 5 -> 16 pulses, then timeout=1 and ctrl_state=0.
- RUN_DIV=4, bp_enable=1, bp_addr=0x10, PC model advancing by 4 per instruction -> pulses every 4 clocks; enters BP_HALT when fetch_pc=0x10 in fetch; btn_run resumes RUN with no immediate re-halt.
- btn_run and btn_cycle rising in the same cycle from IDLE -> RUN entered, no cycle-step pulse; cycle_count forced to 0xFFFFFFFF then one pulse -> cycle_count wraps to 0.

Source files
------------

// File: rtl/cpu_step_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_step_pkg: shared encodings and widths for the CPU step controller |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_step_pkg;

  localparam int CNT_W   = 32;
  localparam int STATE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STEP_INSTR = 2'd1,
    ST_RUN        = 2'd2,
    ST_BP_HALT    = 2'd3
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_step_controller_edge_rise.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_rise: registered rising-edge detector, async active-high reset   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q, level_d;
  logic prev_q, prev_d;
  logic armed_q, armed_d;

  // The first sample after reset seeds both history flops, so a level already
  // high when reset releases is not reported as an edge.
  always_comb begin
    level_d = level;
    prev_d  = armed_q ? level_q : level;
    armed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign rise = level_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_step_controller: button-driven clock-enable sequencer for the CPU |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cpu_step_controller
  import cpu_step_pkg::*;
#(
  parameter logic [STATE_W-1:0] FETCH_STATE      = 4'd0,
  parameter int unsigned        RUN_DIV          = 10_000_000,
  parameter int unsigned        MAX_INSTR_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_cycle,
  input  logic               btn_instr,
  input  logic               btn_run,
  input  logic               bp_enable,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        fetch_pc,
  input  logic [STATE_W-1:0] fsm_state,
  output logic               cpu_ce,
  output logic               running,
  output logic               bp_hit,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count,
  output logic [1:0]         ctrl_state
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int PCW   = $clog2(MAX_INSTR_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RUN_DIV - 1);
  localparam logic [PCW-1:0]   PULSE_MAX = PCW'(MAX_INSTR_CYCLES);

  logic cycle_ev, instr_ev, run_ev;

  edge_rise u_edge_cycle (.clk(clk), .reset(reset), .level(btn_cycle), .rise(cycle_ev));
  edge_rise u_edge_instr (.clk(clk), .reset(reset), .level(btn_instr), .rise(instr_ev));
  edge_rise u_edge_run   (.clk(clk), .reset(reset), .level(btn_run),   .rise(run_ev));

  ctrl_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PCW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic             first_q, first_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             running_q, running_d;
  logic             bp_hit_q, bp_hit_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             bp_match;
  logic             in_fetch;

  assign in_fetch = (fsm_state == FETCH_STATE);
  assign bp_match = bp_enable && in_fetch && (fetch_pc == bp_addr) && first_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    pulse_cnt_d = pulse_cnt_q;
    first_d     = first_q;
    cpu_ce_d    = 1'b0;
    timeout_d   = timeout_q;
    // Counters follow the pulse actually presented to the CPU, so fsm_state
    // is sampled in the same cycle the CPU acts on it.
    cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, cpu_ce_q};
    instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, cpu_ce_q & in_fetch};

    unique case (state_q)
      ST_IDLE, ST_BP_HALT: begin
        if (run_ev) begin
          state_d = ST_RUN;
          div_d   = '0;
          first_d = 1'b0;
        end else if (instr_ev) begin
          state_d     = ST_STEP_INSTR;
          timeout_d   = 1'b0;
          pulse_cnt_d = '0;
        end else if (cycle_ev) begin
          state_d  = ST_IDLE;
          cpu_ce_d = 1'b1;
        end
      end
      ST_STEP_INSTR: begin
        // A pulse on the output now means this cycle is the gap; the check
        // runs on the following cycle once fsm_state has absorbed the pulse.
        if (!cpu_ce_q) begin
          if (pulse_cnt_q == '0) begin
            cpu_ce_d    = 1'b1;
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end else if (in_fetch) begin
            state_d = ST_IDLE;
          end else if (pulse_cnt_q == PULSE_MAX) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cpu_ce_d    = 1'b1;
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (run_ev) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bp_match) begin
            state_d = ST_BP_HALT;
          end else begin
            cpu_ce_d = 1'b1;
            first_d  = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUN);
    bp_hit_d  = (state_d == ST_BP_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      pulse_cnt_q   <= '0;
      first_q       <= 1'b0;
      cpu_ce_q      <= 1'b0;
      running_q     <= 1'b0;
      bp_hit_q      <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      pulse_cnt_q   <= pulse_cnt_d;
      first_q       <= first_d;
      cpu_ce_q      <= cpu_ce_d;
      running_q     <= running_d;
      bp_hit_q      <= bp_hit_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cpu_ce      = cpu_ce_q;
  assign running     = running_q;
  assign bp_hit      = bp_hit_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
  assign ctrl_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_step_controller: scoreboard bench with a toy multi-cycle CPU   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cpu_step_controller;
  import cpu_step_pkg::*;

  localparam int RUN_DIV = 4;
  localparam int MAX_IC  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_cycle = 1'b0, btn_instr = 1'b0, btn_run = 1'b0;
  logic        bp_enable = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] fetch_pc;
  logic [3:0]  fsm_state;
  logic        cpu_ce, running, bp_hit, timeout;
  logic [31:0] cycle_count, instr_count;
  logic [1:0]  ctrl_state;

  cpu_step_controller #(
    .FETCH_STATE(4'd0), .RUN_DIV(RUN_DIV), .MAX_INSTR_CYCLES(MAX_IC)
  ) dut (
    .clk(clk), .reset(reset), .btn_cycle(btn_cycle), .btn_instr(btn_instr),
    .btn_run(btn_run), .bp_enable(bp_enable), .bp_addr(bp_addr),
    .fetch_pc(fetch_pc), .fsm_state(fsm_state), .cpu_ce(cpu_ce),
    .running(running), .bp_hit(bp_hit), .timeout(timeout),
    .cycle_count(cycle_count), .instr_count(instr_count), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  // Toy CPU: four-state instruction 0->1->2->3->0, PC advances by 4 per
  // instruction; in stuck mode the control FSM reports state 5 forever.
  logic [3:0]  cpu_fsm;
  logic [31:0] cpu_pc;
  logic        stuck = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_fsm <= 4'd0;
      cpu_pc  <= 32'h0;
    end else if (cpu_ce && !stuck) begin
      if (cpu_fsm == 4'd3) begin
        cpu_fsm <= 4'd0;
        cpu_pc  <= cpu_pc + 32'd4;
      end else begin
        cpu_fsm <= cpu_fsm + 4'd1;
      end
    end
  end

  assign fsm_state = stuck ? 4'd5 : cpu_fsm;
  assign fetch_pc  = cpu_pc;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [1:0]  st;
    logic [3:0]  fsm;
    logic [31:0] pc;
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [7:0]  gap;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of what the CPU should look like at every pulse.
  int          m_instr_pos = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_cyc = 32'h0;
  logic [31:0] m_ins = 32'h0;

  function automatic logic [3:0] m_fsm_now();
    return stuck ? 4'd5 : 4'(m_instr_pos);
  endfunction

  task automatic push_pulse(input logic [1:0] st, input int gap);
    exp_t e;
    e.st  = st;
    e.fsm = m_fsm_now();
    e.pc  = m_pc;
    m_cyc = m_cyc + 32'd1;
    if (e.fsm == 4'd0) m_ins = m_ins + 32'd1;
    e.cyc = m_cyc;
    e.ins = m_ins;
    e.gap = 8'(gap);
    exp_q.push_back(e);
    if (!stuck) begin
      m_instr_pos = (m_instr_pos + 1) % 4;
      if (m_instr_pos == 0) m_pc = m_pc + 32'd4;
    end
  endtask

  // Instruction step: pulse until the CPU is back in fetch, or the budget runs out.
  task automatic model_instr(output bit exp_timeout);
    int n = 0;
    exp_timeout = 1'b0;
    do begin
      push_pulse(2'(ST_STEP_INSTR), (n == 0) ? 0 : 2);
      n++;
    end while (m_fsm_now() != 4'd0 && n < MAX_IC);
    if (m_fsm_now() != 4'd0) exp_timeout = 1'b1;
  endtask

  // Free run: stop predicting at the breakpoint or after maxp pulses.
  task automatic model_run(input int maxp, output bit halted);
    bit first = 1'b0;
    halted = 1'b0;
    for (int k = 0; k < maxp; k++) begin
      if (bp_enable && first && m_fsm_now() == 4'd0 && m_pc == bp_addr) begin
        halted = 1'b1;
        break;
      end
      push_pulse(2'(ST_RUN), first ? RUN_DIV : 0);
      first = 1'b1;
    end
  endtask

  // Monitor: pops one expectation per observed pulse; counters are checked
  // on the cycle after the pulse.
  int   gap_ctr = 0;
  logic pend = 1'b0;
  exp_t pend_e;
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset) begin
      gap_ctr = 0;
      pend    = 1'b0;
    end else begin
      gap_ctr++;
      if (pend) begin
        check("cycle_count", cycle_count, pend_e.cyc);
        check("instr_count", instr_count, pend_e.ins);
        pend = 1'b0;
      end
      if (cpu_ce) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pulse: cpu_ce=1 in state %0d, no pulse expected", ctrl_state);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_state", 32'(ctrl_state), 32'(mon_e.st));
          check("pulse_fsm", 32'(fsm_state), 32'(mon_e.fsm));
          check("pulse_pc", fetch_pc, mon_e.pc);
          if (mon_e.gap != 8'd0) check("pulse_gap", 32'(gap_ctr), 32'(mon_e.gap));
          pend_e = mon_e;
          pend   = 1'b1;
        end
        gap_ctr = 0;
      end
    end
  end

  task automatic press(input bit c, input bit i, input bit r);
    @(negedge clk);
    btn_cycle = c; btn_instr = i; btn_run = r;
    repeat (3) @(negedge clk);
    btn_cycle = 1'b0; btn_instr = 1'b0; btn_run = 1'b0;
    repeat (1) @(negedge clk);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_state(input string name, input logic [1:0] st, input int budget);
    int n = 0;
    while (ctrl_state != st && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(ctrl_state), 32'(st));
  endtask

  initial begin
    bit to_exp, halted;
    int n_steps;

    // Reset with btn_cycle already held.
    btn_cycle = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("rst_state", 32'(ctrl_state), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_flags", {28'd0, running, bp_hit, timeout, 1'b0}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("held_btn_cycle_count", cycle_count, 32'd0);
    check("held_btn_state", 32'(ctrl_state), 32'd0);
    btn_cycle = 1'b0;
    repeat (3) @(negedge clk);

    // Single-cycle steps.
    n_steps = int'($urandom_range(3, 6));
    for (int s = 0; s < n_steps; s++) begin
      push_pulse(2'(ST_IDLE), 0);
      press(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      wait_drained("cycle_step_drain", 20);
    end

    // Instruction steps from random positions inside an instruction.
    for (int t = 0; t < 3; t++) begin
      n_steps = int'($urandom_range(0, 3));
      for (int s = 0; s < n_steps; s++) begin
        push_pulse(2'(ST_IDLE), 0);
        press(1'b1, 1'b0, 1'b0);
        wait_drained("pre_instr_drain", 20);
      end
      model_instr(to_exp);
      press(1'b0, 1'b1, 1'b0);
      wait_drained("instr_drain", 100);
      wait_state("instr_idle", 2'(ST_IDLE), 20);
      check("instr_timeout", 32'(timeout), 32'(to_exp));
    end

    // Stuck CPU: budget exhausted, timeout is sticky across a cycle step.
    stuck = 1'b1;
    model_instr(to_exp);
    press(1'b0, 1'b1, 1'b0);
    wait_drained("stuck_drain", 200);
    wait_state("stuck_idle", 2'(ST_IDLE), 20);
    check("stuck_timeout", 32'(timeout), 32'(to_exp));
    push_pulse(2'(ST_IDLE), 0);
    press(1'b1, 1'b0, 1'b0);
    wait_drained("stuck_cycle_drain", 20);
    check("timeout_sticky", 32'(timeout), 32'd1);
    stuck = 1'b0;

    // Free run into a breakpoint a few instructions ahead.
    bp_enable = 1'b1;
    bp_addr   = m_pc + 32'd4 * 32'($urandom_range(1, 3));
    model_run(64, halted);
    check("bp_model_halts", 32'(halted), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    wait_state("bp_halt_state", 2'(ST_BP_HALT), 300);
    wait_drained("bp_drain", 20);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_running", 32'(running), 32'd0);

    // Resume at the breakpoint PC: must not re-halt; stop coincides with a tick.
    model_run(6, halted);
    press(1'b0, 1'b0, 1'b1);
    check("resume_running", 32'(running), 32'd1);
    wait_drained("resume_drain", 100);
    press(1'b0, 1'b0, 1'b1);
    wait_state("resume_stop_idle", 2'(ST_IDLE), 20);
    check("resume_stop_running", 32'(running), 32'd0);
    check("resume_stop_bp_hit", 32'(bp_hit), 32'd0);

    // Run and cycle together: run wins; cycle_count wraps on the next pulse.
    bp_enable = 1'b0;
    @(negedge clk);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cycle_count_q;
    m_cyc = 32'hFFFF_FFFF;
    model_run(1, halted);
    press(1'b1, 1'b0, 1'b1);
    check("run_priority_state", 32'(ctrl_state), 32'(ST_RUN));
    check("run_priority_running", 32'(running), 32'd1);
    wait_drained("wrap_drain", 40);
    press(1'b0, 1'b0, 1'b1);
    wait_state("wrap_stop_idle", 2'(ST_IDLE), 20);
    repeat (6) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
